transpose_sequencer: RTL
========================

// Module: transpose_sequencer
// PURPOSE
//  Streams a ROWS x COLUMNS bit frame through a row-to-column transpose.
//  - Accepts ROWS row words of COLUMNS bits each via valid/ready.
//  - Emits COLUMNS column words of ROWS bits each via valid/ready.
//  - Sits between the register/bus side, which writes rows, and serial column consumers.
// PARAMETERS
//  ROWS     4  rows per frame; width of out_col
//  COLUMNS  8  columns per frame; width of in_row
// PORTS
//  clk        in   1                  clock; all logic on rising edge
//  rst        in   1                  asynchronous, active-high reset
//  clear      in   1                  synchronous abort; discards any partial or pending frame
//  in_valid   in   1                  in_row is valid
//  in_ready   out  1                  block accepts a row this cycle
//  in_row     in   COLUMNS            row word; the first row accepted is row 0
//  out_valid  out  1                  out_col is valid
//  out_ready  in   1                  consumer takes out_col this cycle
//  out_col    out  ROWS               column word; column 0 is emitted first
//  out_last   out  1                  high with the final column (COLUMNS-1) of a frame
//  busy       out  1                  a frame is partly filled or not yet fully drained
// BEHAVIOUR
//  - Mapping: out_col[j] = row_j[i] for column index i.
//    Equivalently, packed in bit j*COLUMNS+i -> packed out bit i*ROWS+j.
//  - Handshake: a transfer occurs when valid & ready on a rising edge.
//    - out_valid, out_col and out_last are held stable until out_ready.
//    - out_valid never depends combinationally on out_ready.
//  - FSM has two states: FILL and DRAIN.
//    - FILL: in_ready=1, out_valid=0. Each input transfer writes buffer row row_idx, then row_idx++.
//      When row ROWS-1 is accepted: row_idx->0, col_idx->0, state->DRAIN.
//    - DRAIN: in_ready=0, out_valid=1, out_col = column col_idx, out_last = (col_idx==COLUMNS-1).
//      Each output transfer does col_idx++. The transfer with out_last sends col_idx->0 and state->FILL.
//  - Latency: last row accepted at edge t -> out_valid=1 and column 0 valid after edge t (the cycle following t).
//    Throughput without the option is one frame per ROWS+COLUMNS cycles at full rate.
//  - Counters are sized clog2 of their limit (minimum 1 bit) and never exceed ROWS-1 or COLUMNS-1.
//  - busy = (state==DRAIN) | (row_idx!=0).
//  - Reset (async assert): state=FILL, row_idx=0, col_idx=0, buffer=0.
//    Outputs during and after reset: out_valid=0, out_last=0, out_col=0, in_ready=1, busy=0.
//  - clear: takes effect on the next edge and wins over any simultaneous in/out transfer.
//    - Result is the reset state, except buffer contents, which are don't-care.
//    - No output transfer is counted in the clear cycle.
//  - in_valid while in_ready=0 is ignored (no overwrite). out_ready without out_valid is ignored.
//  - Reset mid-frame drops the partial frame; the first row after reset is row 0.
// CONFIGURATION
//  PINGPONG_EN defined: two frame buffers, fill bank F and drain bank D.
//  - in_ready=1 while F is not complete.
//  - A complete F is handed to D when D is idle, or on the edge of D's out_last transfer.
//    - Back-to-back frames then keep out_valid=1 with no gap; column 0 of the new frame follows column COLUMNS-1.
//  - While F is complete and D is still draining, in_ready=0.
//  - busy = any row in F | D active.
//  - clear empties both banks.
//  PINGPONG_EN undefined: single buffer; FILL and DRAIN are exclusive as above.
// TESTING
//  1. Rows 0x01,0x02,0x04,0x08, out_ready=1 -> out_col 1,2,4,8,0,0,0,0; out_last only on the 8th column.
//  2. Rows 0xFF,0x00,0xFF,0x00 -> all 8 columns = 0x5. Random out_ready stalls keep out_col stable; no column lost or duplicated.
//  3. Reset asserted after 2 rows -> out_valid=0, in_ready=1, busy=0.
//     Then rows 0x80,0,0,0 -> out_col 0,0,0,0,0,0,0,1.
//  4. clear in the same cycle as the 3rd column handshake -> out_valid=0 next cycle, in_ready=1; no further columns emitted.
//  5. in_valid held high during DRAIN with row 0xAA -> no extra row captured.
//     The next frame's data is unaffected; busy stays 1 until the out_last transfer.
//  6. PINGPONG_EN, two frames back-to-back, out_ready=1 -> 16 consecutive out_valid cycles.
//     in_ready=0 while the second frame is complete and the first is draining.

Source files
------------

// File: rtl/transpose_sequencer.sv
// Row-to-column frame transpose with valid/ready on both sides.
// Define PINGPONG_EN for a second frame bank so filling overlaps draining.
module transpose_sequencer #(
    parameter int ROWS    = 4,
    parameter int COLUMNS = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clear,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [COLUMNS-1:0] in_row,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ROWS-1:0]    out_col,
    output logic               out_last,
    output logic               busy
);

    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CW = (COLUMNS > 1) ? $clog2(COLUMNS) : 1;
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);
    localparam logic [CW-1:0] COL_MAX = CW'(COLUMNS - 1);
`ifdef PINGPONG_EN
    localparam int NB = 2;
`else
    localparam int NB = 1;
`endif

    // Encodes the drain side: FILL means nothing is being emitted.
    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [RW-1:0]   row_idx_q, row_idx_d;
    logic [CW-1:0]   col_idx_q, col_idx_d;
    logic [COLUMNS-1:0] mem_q [NB][ROWS];

    logic            wr_bank_s;
    logic            rd_bank_s;
    logic            in_ready_s;
    logic            out_valid_s;
    logic            out_last_s;
    logic            busy_s;
    logic            in_fire_s;
    logic            out_fire_s;
    logic            last_fire_s;
    logic [ROWS-1:0] col_word_s;

    assign in_fire_s   = in_valid & in_ready_s;
    assign out_valid_s = (state_q == DRAIN);
    assign out_fire_s  = out_valid_s & out_ready;
    assign out_last_s  = out_valid_s & (col_idx_q == COL_MAX);
    assign last_fire_s = out_fire_s & out_last_s;

`ifdef PINGPONG_EN
    logic f_sel_q, f_sel_d;
    logic f_full_q, f_full_d;
    logic complete_s;
    logic d_free_s;

    assign wr_bank_s  = f_sel_q;
    assign rd_bank_s  = ~f_sel_q;
    assign in_ready_s = ~f_full_q;
    assign complete_s = f_full_q | (in_fire_s & (row_idx_q == ROW_MAX));
    assign d_free_s   = (state_q == FILL) | last_fire_s;
    assign busy_s     = (state_q == DRAIN) | (row_idx_q != '0) | f_full_q;

    // Next state: fill and drain advance independently; a complete fill bank swaps in when drain frees up.
    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        col_idx_d = col_idx_q;
        f_sel_d   = f_sel_q;
        f_full_d  = f_full_q;
        if (clear) begin
            state_d   = FILL;
            row_idx_d = '0;
            col_idx_d = '0;
            f_sel_d   = 1'b0;
            f_full_d  = 1'b0;
        end else begin
            if (in_fire_s) begin
                row_idx_d = (row_idx_q == ROW_MAX) ? '0 : row_idx_q + RW'(1);
            end else begin
                row_idx_d = row_idx_q;
            end
            if (last_fire_s) begin
                state_d   = FILL;
                col_idx_d = '0;
            end else if (out_fire_s) begin
                col_idx_d = col_idx_q + CW'(1);
            end else begin
                col_idx_d = col_idx_q;
            end
            // Swap on the out_last edge keeps out_valid high across frames.
            if (complete_s && d_free_s) begin
                state_d   = DRAIN;
                col_idx_d = '0;
                f_sel_d   = ~f_sel_q;
                f_full_d  = 1'b0;
            end else begin
                f_full_d  = complete_s;
            end
        end
    end

    // Bank bookkeeping registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            f_sel_q  <= 1'b0;
            f_full_q <= 1'b0;
        end else begin
            f_sel_q  <= f_sel_d;
            f_full_q <= f_full_d;
        end
    end
`else
    assign wr_bank_s  = 1'b0;
    assign rd_bank_s  = 1'b0;
    assign in_ready_s = (state_q == FILL);
    assign busy_s     = (state_q == DRAIN) | (row_idx_q != '0);

    // Next state: fill all rows, then drain all columns, never both at once.
    always_comb begin
        state_d   = state_q;
        row_idx_d = row_idx_q;
        col_idx_d = col_idx_q;
        if (clear) begin
            state_d   = FILL;
            row_idx_d = '0;
            col_idx_d = '0;
        end else begin
            case (state_q)
                FILL: begin
                    if (in_fire_s && (row_idx_q == ROW_MAX)) begin
                        row_idx_d = '0;
                        col_idx_d = '0;
                        state_d   = DRAIN;
                    end else if (in_fire_s) begin
                        row_idx_d = row_idx_q + RW'(1);
                    end else begin
                        row_idx_d = row_idx_q;
                    end
                end
                DRAIN: begin
                    if (last_fire_s) begin
                        col_idx_d = '0;
                        state_d   = FILL;
                    end else if (out_fire_s) begin
                        col_idx_d = col_idx_q + CW'(1);
                    end else begin
                        col_idx_d = col_idx_q;
                    end
                end
                default: begin
                    state_d   = FILL;
                    row_idx_d = '0;
                    col_idx_d = '0;
                end
            endcase
        end
    end
`endif

    // Control state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= FILL;
            row_idx_q <= '0;
            col_idx_q <= '0;
        end else begin
            state_q   <= state_d;
            row_idx_q <= row_idx_d;
            col_idx_q <= col_idx_d;
        end
    end

    // Frame storage: accepted row lands in the fill bank at row_idx.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < NB; b++) begin
                for (int j = 0; j < ROWS; j++) begin
                    mem_q[b][j] <= '0;
                end
            end
        end else begin
            for (int b = 0; b < NB; b++) begin
                for (int j = 0; j < ROWS; j++) begin
                    if (in_fire_s && (int'(wr_bank_s) == b) && (int'(row_idx_q) == j)) begin
                        mem_q[b][j] <= in_row;
                    end else begin
                        mem_q[b][j] <= mem_q[b][j];
                    end
                end
            end
        end
    end

    // Column select: bit j of the output word is bit col_idx of row j.
    always_comb begin
        col_word_s = '0;
        for (int b = 0; b < NB; b++) begin
            for (int j = 0; j < ROWS; j++) begin
                if (int'(rd_bank_s) == b) begin
                    col_word_s[j] = mem_q[b][j][col_idx_q];
                end else begin
                    col_word_s[j] = col_word_s[j];
                end
            end
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_col   = out_valid_s ? col_word_s : '0;
    assign out_last  = out_last_s;
    assign busy      = busy_s;

endmodule
